shift_add_mult_ctrl: RTL and testbench

//  Sequential unsigned WIDTHxWIDTH multiplier controller for the multiplier ALU.

---
 rtl/mult_pkg.sv | 14 +
 rtl/shift_add_datapath.sv | 78 +++++++
 rtl/shift_add_mult_ctrl.sv | 98 +++++++++
 tb/tb_shift_add_mult_ctrl.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared types for the shift-and-add multiplier: FSM state encoding
// and the default operand width.
package mult_pkg;

    localparam int MULT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ADD   = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/shift_add_datapath.sv
// Shift-and-add datapath: multiplicand, accumulator halves, carry bit,
// one WIDTH-bit adder and the registered product.
// Ports: clk, reset (sync, active-high), load_i/add_en_i/shift_en_i/last_i
// controls from the FSM, a_i/b_i operands, product_o result.
module shift_add_datapath
    import mult_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load_i,
    input  logic                 add_en_i,
    input  logic                 shift_en_i,
    input  logic                 last_i,
    input  logic [WIDTH-1:0]     a_i,
    input  logic [WIDTH-1:0]     b_i,
    output logic [2*WIDTH-1:0]   product_o
);

    logic [WIDTH-1:0]   mcand_q,   mcand_d;
    logic [WIDTH-1:0]   acc_hi_q,  acc_hi_d;
    logic [WIDTH-1:0]   acc_lo_q,  acc_lo_d;
    logic               cout_q,    cout_d;
    logic [2*WIDTH-1:0] product_q, product_d;

    // Shared adder, carry-in tied low; bit WIDTH is C4.
    logic [WIDTH:0] sum;
    assign sum = {1'b0, acc_hi_q} + {1'b0, mcand_q};

    always_comb begin
        mcand_d   = mcand_q;
        acc_hi_d  = acc_hi_q;
        acc_lo_d  = acc_lo_q;
        cout_d    = cout_q;
        product_d = product_q;
        if (load_i) begin
            mcand_d  = a_i;
            acc_lo_d = b_i;
            acc_hi_d = '0;
            cout_d   = 1'b0;
        end else if (add_en_i) begin
            if (acc_lo_q[0]) begin
                {cout_d, acc_hi_d} = sum;
            end else begin
                cout_d = 1'b0;
            end
        end else if (shift_en_i) begin
            // Carry drops into the top of acc_hi; the consumed
            // multiplier bit falls off the bottom of acc_lo.
            acc_hi_d = {cout_q, acc_hi_q[WIDTH-1:1]};
            acc_lo_d = {acc_hi_q[0], acc_lo_q[WIDTH-1:1]};
            cout_d   = 1'b0;
            if (last_i) begin
                product_d = {cout_q, acc_hi_q, acc_lo_q[WIDTH-1:1]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mcand_q   <= '0;
            acc_hi_q  <= '0;
            acc_lo_q  <= '0;
            cout_q    <= 1'b0;
            product_q <= '0;
        end else begin
            mcand_q   <= mcand_d;
            acc_hi_q  <= acc_hi_d;
            acc_lo_q  <= acc_lo_d;
            cout_q    <= cout_d;
            product_q <= product_d;
        end
    end

    assign product_o = product_q;

endmodule

// File: rtl/shift_add_mult_ctrl.sv
// Sequential unsigned WIDTHxWIDTH multiplier: FSM and iteration counter
// driving the shift-and-add datapath.
// Ports: clk, reset (sync, active-high), start, a, b in;
// busy, done (one-cycle strobe), product (2*WIDTH, held) out.
module shift_add_mult_ctrl
    import mult_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [CNT_W-1:0]   cnt_inc;
    logic               accept;
    logic               last;
    logic               load, add_en, shift_en;

    assign accept  = start && (state_q == IDLE || state_q == DONE);
    assign cnt_inc = count_q + CNT_W'(1);
    assign last    = (state_q == SHIFT) && (cnt_inc == CNT_W'(WIDTH));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (accept) begin
                    state_d = ADD;
                    count_d = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            ADD: state_d = SHIFT;
            SHIFT: begin
                count_d = cnt_inc;
                state_d = last ? DONE : ADD;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy     = 1'b0;
        done     = 1'b0;
        add_en   = 1'b0;
        shift_en = 1'b0;
        load     = accept;
        unique case (state_q)
            ADD: begin
                busy   = 1'b1;
                add_en = 1'b1;
            end
            SHIFT: begin
                busy     = 1'b1;
                shift_en = 1'b1;
            end
            DONE: done = 1'b1;
            default: ;
        endcase
    end

    shift_add_datapath #(
        .WIDTH(WIDTH)
    ) u_dp (
        .clk        (clk),
        .reset      (reset),
        .load_i     (load),
        .add_en_i   (add_en),
        .shift_en_i (shift_en),
        .last_i     (last),
        .a_i        (a),
        .b_i        (b),
        .product_o  (product)
    );

endmodule

// File: tb/tb_shift_add_mult_ctrl.sv
// Scoreboard bench for shift_add_mult_ctrl (WIDTH=4).
// Expected products and completion cycles are queued at start time.
module tb_shift_add_mult_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [3:0] a, b;
    logic       busy, done;
    logic [7:0] product;

    int passed = 0;
    int total  = 0;
    int cyc    = 0;

    logic [7:0] exp_q[$];
    int         cyc_q[$];

    shift_add_mult_ctrl #(.WIDTH(4)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        if (obs === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Sample just after each rising edge.
    always begin
        @(posedge clk);
        #1;
        cyc++;
        if (busy && done) check("busy_done_excl", {busy, done}, 2'b10);
        if (done) begin
            if (exp_q.size() == 0) begin
                check("spurious_done", 1, 0);
            end else begin
                check("product", product, exp_q.pop_front());
                check("latency_cycle", cyc, cyc_q.pop_front());
            end
        end
    end

    // Called at a negedge; the following edge is the accepting one.
    task automatic op(input logic [3:0] x, input logic [3:0] y,
                      input bit expect_it);
        logic [7:0] p;
        p = 8'(x) * 8'(y);
        a = x;
        b = y;
        start = 1'b1;
        if (expect_it) begin
            exp_q.push_back(p);
            cyc_q.push_back(cyc + 1 + 8);
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            check("drain_timeout", 0, 1);
            exp_q.delete();
            cyc_q.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b1;
        a = 4'h0;
        b = 4'h0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("rst_busy", busy, 0);
            check("rst_done", done, 0);
            check("rst_product", product, 8'h00);
        end
        reset = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check("idle_after_rst", busy, 0);

        op(4'd3, 4'd5, 1);
        check("busy_after_start", busy, 1);
        drain(40);
        repeat (3) @(negedge clk);
        check("product_held", product, 8'h0F);

        op(4'hF, 4'hF, 1);
        @(negedge clk);
        check("product_kept_on_start", product, 8'h0F);
        drain(40);
        op(4'hA, 4'h1, 1);
        drain(40);
        op(4'h0, 4'hF, 1);
        drain(40);
        op(4'hF, 4'h0, 1);
        drain(40);

        op(4'd6, 4'd7, 1);
        repeat (2) @(negedge clk);
        op(4'd1, 4'd1, 0);
        drain(40);
        check("ignored_start_result", product, 8'h2A);

        op(4'd9, 4'd9, 1);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        void'(exp_q.pop_back());
        void'(cyc_q.pop_back());
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_product", product, 8'h00);
        repeat (12) @(negedge clk);
        check("midrst_no_done", product, 8'h00);

        // start held across DONE: second op accepted on the DONE edge.
        a = 4'd2;
        b = 4'd3;
        start = 1'b1;
        exp_q.push_back(8'h06);
        cyc_q.push_back(cyc + 1 + 8);
        exp_q.push_back(8'h14);
        cyc_q.push_back(cyc + 1 + 17);
        @(negedge clk);
        a = 4'd4;
        b = 4'd5;
        repeat (9) @(negedge clk);
        start = 1'b0;
        drain(40);
        repeat (12) @(negedge clk);
        check("final_product", product, 8'h14);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL global_timeout: got 0 expected 1");
        $fatal(1);
    end

endmodule
